dtcm_arb: RTL and testbench

- Two-requester arbiter that shares the single DTCM controller command/response port.
- Requester 0 is the core LSU; requester 1 is the debug/DMA port.
- Sits between the requesters and dtcm_ctrl. It grants commands round-robin, holds a grant stable while a command is stalled, and tracks the owner of each in-flight command in an ID FIFO so responses return in order to the correct requester.

---
 rtl/dtcm_arb.sv | 168 ++++++++++++++++
 tb/tb_dtcm_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dtcm_arb.sv
// ============================================================================
//  Module   : dtcm_arb
//  Purpose  : Two-requester round-robin arbiter in front of the DTCM
//             controller. Requester 0 is the core LSU, requester 1 is the
//             debug/DMA port. Grants are held while a command is stalled, and
//             an ID FIFO routes in-order responses back to their owners.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtcm_arb #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int OUTS_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  // requester 0 (core LSU)
  input  logic          m0_cmd_valid,
  output logic          m0_cmd_ready,
  input  logic          m0_cmd_read,
  input  logic [AW-1:0] m0_cmd_addr,
  input  logic [DW-1:0] m0_cmd_wdata,
  input  logic [MW-1:0] m0_cmd_wmask,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_rdata,
  // requester 1 (debug/DMA)
  input  logic          m1_cmd_valid,
  output logic          m1_cmd_ready,
  input  logic          m1_cmd_read,
  input  logic [AW-1:0] m1_cmd_addr,
  input  logic [DW-1:0] m1_cmd_wdata,
  input  logic [MW-1:0] m1_cmd_wmask,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_rdata,
  // shared DTCM controller port
  output logic          s_cmd_valid,
  input  logic          s_cmd_ready,
  output logic          s_cmd_read,
  output logic [AW-1:0] s_cmd_addr,
  output logic [DW-1:0] s_cmd_wdata,
  output logic [MW-1:0] s_cmd_wmask,
  input  logic          s_rsp_valid,
  output logic          s_rsp_ready,
  input  logic [DW-1:0] s_rsp_rdata,
  output logic          arb_busy
);

  localparam int            PW       = $clog2(OUTS_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(OUTS_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // one owner bit per outstanding command, in issue order
  logic [OUTS_DEPTH-1:0] id_fifo;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

  logic last_grant;
  logic hold;
  logic hold_id;

  logic grant;
  logic grant_vld;
  logic full;
  logic not_empty;
  logic head;
  logic push;
  logic pop;

  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);
  assign head      = id_fifo[rd_ptr];
  assign arb_busy  = not_empty;

  // Grant selection: a stalled command keeps its owner, otherwise round-robin
  always_comb begin
    grant     = 1'b0;
    grant_vld = 1'b0;
    if (hold) begin
      grant     = hold_id;
      grant_vld = hold_id ? m1_cmd_valid : m0_cmd_valid;
    end else if (m0_cmd_valid && m1_cmd_valid) begin
      grant     = ~last_grant;
      grant_vld = 1'b1;
    end else if (m1_cmd_valid) begin
      grant     = 1'b1;
      grant_vld = 1'b1;
    end else if (m0_cmd_valid) begin
      grant     = 1'b0;
      grant_vld = 1'b1;
    end
  end

  // Command mux towards the controller; fields are zero when nobody is granted
  always_comb begin
    s_cmd_valid  = grant_vld & ~full;
    s_cmd_read   = 1'b0;
    s_cmd_addr   = '0;
    s_cmd_wdata  = '0;
    s_cmd_wmask  = '0;
    if (grant_vld) begin
      s_cmd_read  = grant ? m1_cmd_read  : m0_cmd_read;
      s_cmd_addr  = grant ? m1_cmd_addr  : m0_cmd_addr;
      s_cmd_wdata = grant ? m1_cmd_wdata : m0_cmd_wdata;
      s_cmd_wmask = grant ? m1_cmd_wmask : m0_cmd_wmask;
    end
    m0_cmd_ready = grant_vld & ~grant & ~full & s_cmd_ready;
    m1_cmd_ready = grant_vld &  grant & ~full & s_cmd_ready;
  end

  // Response routing to the owner at the FIFO head; stray responses stall
  always_comb begin
    m0_rsp_valid = not_empty & ~head & s_rsp_valid;
    m1_rsp_valid = not_empty &  head & s_rsp_valid;
    s_rsp_ready  = not_empty & (head ? m1_rsp_ready : m0_rsp_ready);
    m0_rsp_rdata = s_rsp_rdata;
    m1_rsp_rdata = s_rsp_rdata;
  end

  assign push = s_cmd_valid & s_cmd_ready;
  assign pop  = s_rsp_valid & s_rsp_ready;

  // ID FIFO: pointers wrap naturally, full blocks push even on a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      id_fifo <= '0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push && pop) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Arbitration state: round-robin pointer and the stall hold latch
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      hold       <= 1'b0;
      hold_id    <= 1'b0;
    end else if (push) begin
      last_grant <= grant;
      hold       <= 1'b0;
    end else if (s_cmd_valid) begin
      hold    <= 1'b1;
      hold_id <= grant;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dtcm_arb.sv
// ============================================================================
//  Module   : tb_dtcm_arb
//  Purpose  : Self-checking bench for dtcm_arb. A queue-based reference model
//             of the arbiter predicts every output each cycle; directed
//             sequences pin the model with literal expectations, then random
//             traffic with occasional resets exercises the rest.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dtcm_arb;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          mv    [2];
  logic          mcr   [2];
  logic          mrd   [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwd   [2];
  logic [MW-1:0] mwm   [2];
  logic          mrv   [2];
  logic          mrr   [2];
  logic [DW-1:0] mrdata[2];

  logic          scv, scr, scrd, srv, srr, busy;
  logic [AW-1:0] scaddr;
  logic [DW-1:0] scwd, srdata;
  logic [MW-1:0] scwm;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int          q[$];      // owner of each outstanding command, oldest first
  logic [31:0] cq[$];     // controller-side pending read data
  bit          last_g  = 1'b1;
  bit          held    = 1'b0;
  bit          held_id = 1'b0;
  bit          acc[2];
  bit          prev_rst;

  always #5 clk = ~clk;

  dtcm_arb #(.AW(AW), .DW(DW), .MW(MW), .OUTS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_cmd_valid(mv[0]), .m0_cmd_ready(mcr[0]), .m0_cmd_read(mrd[0]),
    .m0_cmd_addr(maddr[0]), .m0_cmd_wdata(mwd[0]), .m0_cmd_wmask(mwm[0]),
    .m0_rsp_valid(mrv[0]), .m0_rsp_ready(mrr[0]), .m0_rsp_rdata(mrdata[0]),
    .m1_cmd_valid(mv[1]), .m1_cmd_ready(mcr[1]), .m1_cmd_read(mrd[1]),
    .m1_cmd_addr(maddr[1]), .m1_cmd_wdata(mwd[1]), .m1_cmd_wmask(mwm[1]),
    .m1_rsp_valid(mrv[1]), .m1_rsp_ready(mrr[1]), .m1_rsp_rdata(mrdata[1]),
    .s_cmd_valid(scv), .s_cmd_ready(scr), .s_cmd_read(scrd),
    .s_cmd_addr(scaddr), .s_cmd_wdata(scwd), .s_cmd_wmask(scwm),
    .s_rsp_valid(srv), .s_rsp_ready(srr), .s_rsp_rdata(srdata),
    .arb_busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Predict outputs from the current inputs, compare, then advance one edge
  task automatic tick();
    bit full, gv, gid, head, hs, pop, e_scv, e_srr;
    bit e_mcr[2];
    bit e_mrv[2];
    #1;
    full = (q.size() == DEPTH);
    gv = 1'b0; gid = 1'b0;
    if (held) begin
      gid = held_id; gv = mv[held_id];
    end else if (mv[0] && mv[1]) begin
      gid = !last_g; gv = 1'b1;
    end else if (mv[1]) begin
      gid = 1'b1; gv = 1'b1;
    end else if (mv[0]) begin
      gid = 1'b0; gv = 1'b1;
    end
    e_scv = gv && !full;
    head  = (q.size() > 0) ? q[0][0] : 1'b0;
    e_srr = (q.size() > 0) && mrr[head];
    chk("s_cmd_valid", scv, e_scv);
    chk("s_cmd_read",  scrd,   gv ? mrd[gid]   : 1'b0);
    chk("s_cmd_addr",  scaddr, gv ? maddr[gid] : '0);
    chk("s_cmd_wdata", scwd,   gv ? mwd[gid]   : '0);
    chk("s_cmd_wmask", scwm,   gv ? mwm[gid]   : '0);
    for (int x = 0; x < 2; x++) begin
      e_mcr[x] = gv && (gid == x) && !full && scr;
      e_mrv[x] = (q.size() > 0) && (head == x) && srv;
      chk($sformatf("m%0d_cmd_ready", x), mcr[x], e_mcr[x]);
      chk($sformatf("m%0d_rsp_valid", x), mrv[x], e_mrv[x]);
      chk($sformatf("m%0d_rsp_rdata", x), mrdata[x], srdata);
      acc[x] = e_mcr[x];
    end
    chk("s_rsp_ready", srr, e_srr);
    chk("arb_busy", busy, q.size() > 0);
    hs  = e_scv && scr;
    pop = srv && e_srr;
    @(posedge clk);
    prev_rst = rst;
    if (rst) begin
      q.delete(); cq.delete();
      last_g = 1'b1; held = 1'b0; held_id = 1'b0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        if (cq.size() > 0) void'(cq.pop_front());
      end
      if (hs) begin
        q.push_back(int'(gid));
        cq.push_back($urandom);
        last_g = gid;
        held   = 1'b0;
      end else if (e_scv) begin
        held = 1'b1; held_id = gid;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    for (int x = 0; x < 2; x++) begin
      mv[x] = 0; mrd[x] = 0; maddr[x] = '0; mwd[x] = '0; mwm[x] = '0; mrr[x] = 0;
    end
    scr = 0; srv = 0; srdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // reset state, then a single m0 read with a one-cycle response
    #1;
    chk("d_rst_busy", busy, 0);
    chk("d_rst_scv", scv, 0);
    chk("d_rst_srr", srr, 0);
    mv[0] = 1; mrd[0] = 1; maddr[0] = 16'h0010; scr = 1;
    #1;
    chk("d_rd_scv", scv, 1);
    chk("d_rd_addr", scaddr, 32'h0010);
    chk("d_rd_read", scrd, 1);
    tick();
    mv[0] = 0; srv = 1; srdata = 32'hDEADBEEF; mrr[0] = 1;
    #1;
    chk("d_rd_m0rv", mrv[0], 1);
    chk("d_rd_rdata", mrdata[0], 32'hDEADBEEF);
    chk("d_rd_m1rv", mrv[1], 0);
    tick();
    srv = 0;
    #1;
    chk("d_rd_busy", busy, 0);

    // contention: m0 first after reset, full blocks, issue resumes after pop
    rst = 1; tick(); rst = 0;
    mv[0] = 1; mv[1] = 1; mrr[0] = 1; mrr[1] = 1; scr = 1;
    #1; chk("d_rr_first_m0", mcr[0], 1);
    tick();
    #1; chk("d_rr_then_m1", mcr[1], 1);
    tick();
    srv = 1; srdata = 32'h1;
    #1;
    chk("d_full_scv", scv, 0);
    chk("d_full_m0rv", mrv[0], 1);
    tick();
    srdata = 32'h2;
    #1;
    chk("d_pop_m1rv", mrv[1], 1);
    chk("d_after_pop_m0", mcr[0], 1);
    tick();
    mv[0] = 0; mv[1] = 0; srv = 0;
    tick();

    // hold: m1 stalled while m0 appears, m1 must still win
    rst = 1; tick(); rst = 0;
    scr = 0; mv[1] = 1; maddr[1] = 16'h0111;
    #1; chk("d_hold_addr0", scaddr, 32'h0111);
    tick();
    mv[0] = 1; maddr[0] = 16'h00A0;
    #1;
    chk("d_hold_addr1", scaddr, 32'h0111);
    chk("d_hold_m0rdy", mcr[0], 0);
    tick();
    tick();
    scr = 1;
    #1; chk("d_hold_m1acc", mcr[1], 1);
    tick();
    mv[1] = 0;
    #1;
    chk("d_hold_m0next", mcr[0], 1);
    chk("d_hold_m0addr", scaddr, 32'h00A0);
    tick();
    mv[0] = 0;

    // reset with two outstanding: stray response stalls, m0 has priority
    rst = 1; tick(); rst = 0;
    srv = 1; mv[0] = 1; mv[1] = 1;
    #1;
    chk("d_rst2_busy", busy, 0);
    chk("d_rst2_srr", srr, 0);
    chk("d_rst2_m1rv", mrv[1], 0);
    chk("d_rst2_m0pri", mcr[0], 1);
    tick();
    idle_inputs();
    rst = 1; tick(); rst = 0;

    // random traffic
    acc[0] = 0; acc[1] = 0; prev_rst = 1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int x = 0; x < 2; x++) begin
        if (prev_rst || !mv[x] || acc[x]) begin
          mv[x]    = ($urandom_range(0, 3) != 0);
          mrd[x]   = 1'($urandom_range(0, 1));
          maddr[x] = AW'($urandom);
          mwd[x]   = $urandom;
          mwm[x]   = MW'($urandom);
        end
        mrr[x] = ($urandom_range(0, 3) != 0);
      end
      scr = ($urandom_range(0, 3) != 0);
      if (cq.size() > 0) begin
        srv    = ($urandom_range(0, 2) != 0);
        srdata = srv ? cq[0] : $urandom;
      end else begin
        srv    = ($urandom_range(0, 9) == 0);
        srdata = $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
